mem_delayed: RTL

MEM_DELAYED -- requirements
Module: mem_delayed

---
 rtl/mem_delayed.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_delayed.sv
// mem_delayed: DEPTH x 16-bit memory with a fixed-latency, fully pipelined read port.
// One read is accepted per cycle. Each read carries its data and its out-of-range
// flag down a LATENCY-deep valid/data pipeline, so responses come back in request order.
// A read of an address >= DEPTH returns 0 with rd_err set. Writes to such addresses are dropped.
module mem_delayed #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [15:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic        rd_err,
  output logic [3:0]  rd_pending,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [15:0]        mem_q [DEPTH];

  logic               rd_in_range;
  logic               wr_in_range;
  logic [AW-1:0]      rd_idx;
  logic [AW-1:0]      wr_idx;

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [15:0]        data_q [LATENCY];
  logic [15:0]        data_d [LATENCY];
  logic [3:0]         pending_q, pending_d;

  // The range check uses the full 16-bit address, so an out-of-range
  // address can never alias onto a low word.
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_idx      = rd_addr[AW-1:0];
  assign wr_idx      = wr_addr[AW-1:0];

  // Storage is not reset. Writes are ignored while rst is high.
  // The non-blocking update means a read on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (wr_req && !rst && wr_in_range) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Next-state for the read pipeline and the outstanding-read counter.
  always_comb begin
    valid_d = '0;
    err_d   = '0;
    for (int i = 0; i < LATENCY; i++) begin
      data_d[i] = data_q[i];
    end

    // Stage 0 samples the array on the accepting edge.
    valid_d[0] = rd_req;
    err_d[0]   = rd_req & ~rd_in_range;
    if (rd_req) begin
      data_d[0] = rd_in_range ? mem_q[rd_idx] : 16'h0000;
    end

    // Data only advances behind a valid bit. This lets the last stage hold
    // the most recent response between acks.
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = valid_q[i-1] & err_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end

    pending_d = pending_q + 4'(rd_req) - 4'(valid_q[LATENCY-1]);
  end

  // Pipeline and counter registers.
  // Reset clears them at once, so any in-flight reads are lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      err_q     <= '0;
      pending_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign rd_ack     = valid_q[LATENCY-1];
  assign rd_err     = err_q[LATENCY-1];
  assign rd_data    = data_q[LATENCY-1];
  assign rd_pending = pending_q;

endmodule
